// File: rtl/noc_recv_buffer_if.sv
// Handshake/bus bundle between the NoC receive buffer and the Nios PIO side.
// The master drives NoC words and software controls; the slave is the buffer itself.
interface noc_recv_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] noc_in;
    logic                  ack_toggle;
    logic                  clr_ovf;
    logic [DATA_WIDTH-1:0] recv_data;
    logic [7:0]            recv_addr;
    logic                  fifo_full;

    modport master (
        output noc_in,
        output ack_toggle,
        output clr_ovf,
        input  recv_data,
        input  recv_addr,
        input  fifo_full
    );

    modport slave (
        input  noc_in,
        input  ack_toggle,
        input  clr_ovf,
        output recv_data,
        output recv_addr,
        output fifo_full
    );
endinterface

// File: rtl/noc_recv_buffer.sv
// Receive-side FIFO between the TDMA NoC output port and a Nios core's recv PIOs.
// Software pops the head word by changing the level of ack_toggle.
module noc_recv_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int VALID_BIT  = 31,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    noc_recv_buffer_if.slave       bus
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [5:0]            count;
    logic                  ovf;
    logic                  ack_q;

    logic nonempty;
    logic full;
    logic push_req;
    logic pop_req;
    logic do_push;
    logic do_pop;
    logic ovf_set;

    // A pop can free a slot in the same cycle, so a full FIFO still accepts a push then.
    always_comb begin
        nonempty = (count != 6'd0);
        full     = (count == 6'(DEPTH));
        push_req = bus.noc_in[VALID_BIT];
        pop_req  = (bus.ack_toggle != ack_q);
        do_pop   = pop_req && nonempty;
        do_push  = push_req && (!full || do_pop);
        ovf_set  = push_req && full && !do_pop;
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= bus.noc_in;
        end
    end

    // ack_q follows the pin even in reset so a level held through reset never pops.
    always_ff @(posedge clk) begin
        ack_q <= bus.ack_toggle;
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 6'd0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 6'd1;
                2'b01:   count <= count - 6'd1;
                default: count <= count;
            endcase
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    assign bus.recv_data = nonempty ? mem[rd_ptr] : '0;
    assign bus.recv_addr = {nonempty, ovf, count};
    assign bus.fifo_full = full;
endmodule

// File: tb/tb_noc_recv_buffer.sv
// Scoreboard bench for noc_recv_buffer: the driver queues every accepted word and a
// negedge monitor checks the head word each time software pops it.
module tb_noc_recv_buffer;
    logic clk;
    logic reset;

    noc_recv_buffer_if #(.DATA_WIDTH(32)) bus ();

    noc_recv_buffer #(
        .DATA_WIDTH(32),
        .VALID_BIT (31),
        .DEPTH     (8),
        .PTR_WIDTH (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          tests_run;
    int          tests_failed;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;
    logic        mon_ack;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mon_ack <= bus.ack_toggle;
    end

    // A pop is observed when the pin differs from last edge's level and the head is valid.
    always @(negedge clk) begin
        if (!reset && (bus.ack_toggle != mon_ack) && bus.recv_addr[7]) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL pop_data: got %h, expected no word queued", bus.recv_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.recv_data !== mon_exp) begin
                    tests_failed++;
                    $display("[TB] FAIL pop_data: got %h, expected %h", bus.recv_data, mon_exp);
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [31:0] word, input logic flip,
                                  input logic clr, input bit accept);
        bus.noc_in  = word;
        bus.clr_ovf = clr;
        if (flip) begin
            bus.ack_toggle = ~bus.ack_toggle;
        end
        if (accept) begin
            exp_q.push_back(word);
        end
        @(posedge clk);
        #1;
        bus.noc_in  = 32'h0;
        bus.clr_ovf = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(32'h0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic pop_words(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(32'h0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic check_output(input string name, input logic [7:0] exp_addr,
                                input logic [31:0] exp_data, input logic exp_full);
        tests_run++;
        if (bus.recv_addr !== exp_addr || bus.recv_data !== exp_data || bus.fifo_full !== exp_full) begin
            tests_failed++;
            $display("[TB] FAIL %s: got addr=%h data=%h full=%b, expected addr=%h data=%h full=%b",
                     name, bus.recv_addr, bus.recv_data, bus.fifo_full, exp_addr, exp_data, exp_full);
        end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        clk            = 1'b0;
        reset          = 1'b1;
        bus.noc_in     = 32'h0;
        bus.ack_toggle = 1'b1;
        bus.clr_ovf    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state with ack held high, then idle.
        check_output("reset", 8'h00, 32'h0, 1'b0);
        idle(5);
        check_output("idle", 8'h00, 32'h0, 1'b0);

        // Single word in and out.
        apply_stimulus(32'h8000_00A5, 1'b0, 1'b0, 1'b1);
        check_output("single_push", 8'h81, 32'h8000_00A5, 1'b0);
        pop_words(1);
        check_output("single_pop", 8'h00, 32'h0, 1'b0);

        // A word without the valid bit is ignored.
        apply_stimulus(32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0);
        check_output("invalid_word", 8'h00, 32'h0, 1'b0);

        // Pop on empty is discarded and does not linger.
        pop_words(1);
        check_output("empty_pop", 8'h00, 32'h0, 1'b0);

        // Fill, overflow, drain, clear.
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(32'h8000_1000 + 32'(i), 1'b0, 1'b0, 1'b1);
        end
        check_output("full", 8'h88, 32'h8000_1001, 1'b1);
        apply_stimulus(32'h8000_1009, 1'b0, 1'b0, 1'b0);
        check_output("overflow", 8'hC8, 32'h8000_1001, 1'b1);
        pop_words(8);
        check_output("drained_ovf", 8'h40, 32'h0, 1'b0);
        apply_stimulus(32'h0, 1'b0, 1'b1, 1'b0);
        check_output("clr_ovf", 8'h00, 32'h0, 1'b0);

        // Full FIFO with simultaneous push and pop: no overflow, new word at tail.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(32'h8000_2000 + 32'(i), 1'b0, 1'b0, 1'b1);
        end
        apply_stimulus(32'h8000_20FF, 1'b1, 1'b0, 1'b1);
        check_output("full_push_pop", 8'h88, 32'h8000_2001, 1'b1);
        pop_words(8);
        check_output("full_push_pop_drain", 8'h00, 32'h0, 1'b0);

        // Overflow and clear in the same cycle: the set wins.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(32'h8000_3000 + 32'(i), 1'b0, 1'b0, 1'b1);
        end
        apply_stimulus(32'h8000_30FF, 1'b0, 1'b1, 1'b0);
        check_output("ovf_set_wins", 8'hC8, 32'h8000_3000, 1'b1);
        apply_stimulus(32'h0, 1'b0, 1'b1, 1'b0);
        check_output("ovf_cleared_full", 8'h88, 32'h8000_3000, 1'b1);
        pop_words(8);
        check_output("ovf_drain", 8'h00, 32'h0, 1'b0);

        // Empty FIFO with simultaneous push and pop: only the push happens.
        apply_stimulus(32'h8000_00E5, 1'b1, 1'b0, 1'b1);
        check_output("empty_push_pop", 8'h81, 32'h8000_00E5, 1'b0);
        pop_words(1);
        check_output("empty_push_pop_drain", 8'h00, 32'h0, 1'b0);

        // Reset mid-operation while toggling ack.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(32'h8000_5000 + 32'(i), 1'b0, 1'b0, 1'b1);
        end
        check_output("pre_reset", 8'h83, 32'h8000_5000, 1'b0);
        reset          = 1'b1;
        bus.ack_toggle = ~bus.ack_toggle;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_output("mid_reset", 8'h00, 32'h0, 1'b0);
        idle(1);
        check_output("post_reset", 8'h00, 32'h0, 1'b0);
        apply_stimulus(32'h8000_6001, 1'b0, 1'b0, 1'b1);
        check_output("post_reset_push", 8'h81, 32'h8000_6001, 1'b0);
        pop_words(1);
        check_output("post_reset_pop", 8'h00, 32'h0, 1'b0);

        idle(2);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: got %0d words left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
